// File: rtl/uart_tx_arbiter.sv
// N-channel UART transmit arbiter: per-channel byte FIFOs feeding one transmit port,
// round-robin or fixed-priority selection, at most one byte per frame time.
module uart_tx_arbiter #(
   parameter  int NUM_CH     = 2,
   parameter  int DATA_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   parameter  int GAP_CYCLES = 160,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_CH*DATA_W-1:0] ch_bits_i,
   input  logic [NUM_CH-1:0]        ch_valid_i,
   input  logic [NUM_CH-1:0]        ch_enable_i,
   input  logic                     prio_mode_i,
   output logic [DATA_W-1:0]        tx_bits_o,
   output logic                     tx_pulse_o,
   output logic [NUM_CH-1:0]        ch_full_o,
   output logic [NUM_CH-1:0]        ch_overflow_o,
   output logic [CH_W-1:0]          active_ch_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CH_W + 1;
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [DATA_W-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
   logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [NUM_CH-1:0] ovf_q;

   logic [1:0]        state_q, state_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [DATA_W-1:0] tx_bits_q, tx_bits_d;
   logic              tx_pulse_q, tx_pulse_d;
   logic [CH_W-1:0]   active_q, active_d;
   logic [CH_W-1:0]   rr_q, rr_d;

   logic [NUM_CH-1:0] cand, pop, push_ok, drop;
   logic              gnt_any, grant;
   logic [CH_W-1:0]   gnt_idx, srch_idx, srch_base;
   logic [SUM_W-1:0]  srch_sum;
   logic [DATA_W-1:0] head;

   // A FIFO can only hold data if its channel was enabled at the last edge, so occupancy
   // alone qualifies a candidate; a grant landing on a disable cycle still takes the head.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cand[i]    = (cnt_q[i] != '0);
         pop[i]     = grant && (gnt_idx == CH_W'(i));
         push_ok[i] = ch_valid_i[i] && ch_enable_i[i] && ((cnt_q[i] != DEPTH) || pop[i]);
         drop[i]    = ch_valid_i[i] && ch_enable_i[i] && (cnt_q[i] == DEPTH) && !pop[i];
         ch_full_o[i] = (cnt_q[i] == DEPTH);
      end
   end

   // Search from the base offset; walking offsets downward leaves the nearest hit in gnt_idx.
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      srch_sum  = '0;
      srch_idx  = '0;
      srch_base = prio_mode_i ? '0 : rr_q;
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         srch_sum = {1'b0, srch_base} + SUM_W'(off);
         if (srch_sum >= SUM_W'(NUM_CH))
            srch_sum = srch_sum - SUM_W'(NUM_CH);
         srch_idx = srch_sum[CH_W-1:0];
         if (cand[srch_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = srch_idx;
         end
      end
   end

   assign grant = (state_q == S_IDLE) && gnt_any;

   always_comb begin
      head = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (gnt_idx == CH_W'(i)) head = mem_q[i][rd_ptr_q[i]];
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_CH; i++)
         if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= ch_bits_i[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_CH; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (drop[i]) ovf_q[i] <= 1'b1;
            if (!ch_enable_i[i]) begin
               rd_ptr_q[i] <= '0;
               wr_ptr_q[i] <= '0;
               cnt_q[i]    <= '0;
            end else begin
               if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
               if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
               cnt_q[i] <= cnt_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      tx_bits_d  = tx_bits_q;
      tx_pulse_d = 1'b0;
      active_d   = active_q;
      rr_d       = rr_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               tx_bits_d  = head;
               tx_pulse_d = 1'b1;
               active_d   = gnt_idx;
               rr_d       = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            gap_d   = GAP_LOAD;
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            gap_d = gap_q - GAP_W'(1);
            if (gap_q <= GAP_W'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         gap_q      <= '0;
         tx_bits_q  <= '0;
         tx_pulse_q <= 1'b0;
         active_q   <= '0;
         rr_q       <= '0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         tx_bits_q  <= tx_bits_d;
         tx_pulse_q <= tx_pulse_d;
         active_q   <= active_d;
         rr_q       <= rr_d;
      end
   end

   assign tx_bits_o     = tx_bits_q;
   assign tx_pulse_o    = tx_pulse_q;
   assign active_ch_o   = active_q;
   assign ch_overflow_o = ovf_q;

endmodule
